// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, requester ids and default sizes.
// Consumed by ram_arbiter_2p and rr_arb2.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_RD_LAT = 1;

    // Wide enough for RD_LAT-1 with RD_LAT up to 3.
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way requester picker. Round-robin on ties by default; fixed priority to req0
// when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output req_id_t    grant,
    output logic       any_req
);

    assign any_req = |req;

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant = REQ0;
        case (req)
            2'b10: grant = REQ1;
            2'b11: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                grant = REQ0;
`else
                // Tie goes to whoever was not served last, so contention alternates.
                grant = (last_grant == REQ0) ? REQ1 : REQ0;
`endif
            end
            default: grant = REQ0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port synchronous RAM between two req/ack requesters.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (req0) instead of round-robin.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int RD_LAT = RAM_RD_LAT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output state_t            dbg_state
);

    // Handshake: a requester raises reqN with we/addr/wdata stable and holds them until
    // ackN pulses for one cycle; the command is taken only while IDLE, and a req still
    // high in IDLE after its ack counts as a fresh request. rdata is valid with ackN of a read.

    state_t           state;
    state_t           state_next;
    logic             start;
    logic [CNT_W-1:0] cnt;
    req_id_t          owner;
    req_id_t          last_grant;
    req_id_t          grant;
    logic             any_req;
    logic             we_sel;

    rr_arb2 u_arb (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .grant      (grant),
        .any_req    (any_req)
    );

    assign we_sel    = (grant == REQ1) ? we1 : we0;
    assign dbg_state = state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ram_wren is high exactly during ISSUE of a write, so it doubles as the op type there.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                    start      = 1'b1;
                end
            end
            ISSUE:   state_next = ram_wren ? IDLE : WAIT;
            WAIT:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            cnt         <= '0;
            owner       <= REQ0;
            last_grant  <= REQ1;
        end else begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            ram_wren <= 1'b0;
            busy     <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        ram_address <= (grant == REQ1) ? addr1 : addr0;
                        ram_data    <= (grant == REQ1) ? wdata1 : wdata0;
                        ram_wren    <= we_sel;
                        owner       <= grant;
                        last_grant  <= grant;
                        // A write completes in ISSUE, so its ack rides along with wren.
                        ack0        <= we_sel && (grant == REQ0);
                        ack1        <= we_sel && (grant == REQ1);
                    end
                end
                ISSUE: begin
                    cnt <= CNT_W'(RD_LAT - 1);
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rdata <= ram_q;
                        ack0  <= (owner == REQ0);
                        ack1  <= (owner == REQ1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p: one RD_LAT=1 instance and one RD_LAT=2 instance
// driven in lockstep, each with its own behavioural 64x8 RAM.
module tb_ram_arbiter_2p;
    import ram_arb_pkg::*;

    logic       clock;
    logic       resetn;
    logic       req0_a, req1_a, req0_b, req1_b;
    logic       we0, we1;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;

    logic       ack0_a, ack1_a, busy_a, ram_wren_a;
    logic [7:0] rdata_a, ram_data_a, ram_q_a;
    logic [5:0] ram_address_a;
    state_t     dbg_state_a;

    logic       ack0_b, ack1_b, busy_b, ram_wren_b;
    logic [7:0] rdata_b, ram_data_b, ram_q_b;
    logic [5:0] ram_address_b;
    state_t     dbg_state_b;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUTs ----------------
    ram_arbiter_2p #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1)) u_dut_a (
        .clock(clock), .resetn(resetn), .req0(req0_a), .req1(req1_a),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0_a), .ack1(ack1_a),
        .rdata(rdata_a), .busy(busy_a), .ram_address(ram_address_a),
        .ram_data(ram_data_a), .ram_wren(ram_wren_a), .ram_q(ram_q_a),
        .dbg_state(dbg_state_a)
    );

    ram_arbiter_2p #(.ADDR_W(6), .DATA_W(8), .RD_LAT(2)) u_dut_b (
        .clock(clock), .resetn(resetn), .req0(req0_b), .req1(req1_b),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0_b), .ack1(ack1_b),
        .rdata(rdata_b), .busy(busy_b), .ram_address(ram_address_b),
        .ram_data(ram_data_b), .ram_wren(ram_wren_b), .ram_q(ram_q_b),
        .dbg_state(dbg_state_b)
    );

    // ---------------- RAM models ----------------
    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    logic [5:0] areg_a, areg_b;
    logic [7:0] qreg_b;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        areg_a = '0;
        areg_b = '0;
        qreg_b = '0;
    end

    assign ram_q_a = mem_a[areg_a];
    assign ram_q_b = qreg_b;

    always @(posedge clock) begin
        if (ram_wren_a) mem_a[ram_address_a] <= ram_data_a;
        areg_a <= ram_address_a;
        if (ram_wren_b) mem_b[ram_address_b] <= ram_data_b;
        areg_b <= ram_address_b;
        qreg_b <= mem_b[areg_b];
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drop_all();
        req0_a = 1'b0; req1_a = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        drop_all();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // One access on both DUTs; expected latency: write 1, read 2+RD_LAT.
    task automatic access(input int id, input logic we, input logic [5:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
        int lat_a, lat_b, wren_a, wren_b, wrong;
        logic done_a, done_b;
        logic [7:0] rd_a, rd_b;
        lat_a = -1; lat_b = -1; wren_a = 0; wren_b = 0; wrong = 0;
        done_a = 1'b0; done_b = 1'b0; rd_a = '0; rd_b = '0;
        if (id == 0) begin
            we0 = we; addr0 = addr; wdata0 = wd; req0_a = 1'b1; req0_b = 1'b1;
        end else begin
            we1 = we; addr1 = addr; wdata1 = wd; req1_a = 1'b1; req1_b = 1'b1;
        end
        for (int c = 0; c < 16 && !(done_a && done_b); c++) begin
            @(negedge clock);
            if (ram_wren_a) wren_a++;
            if (ram_wren_b) wren_b++;
            if ((id == 0) ? ack1_a : ack0_a) wrong++;
            if ((id == 0) ? ack1_b : ack0_b) wrong++;
            if (!done_a && ((id == 0) ? ack0_a : ack1_a)) begin
                done_a = 1'b1; lat_a = c; rd_a = rdata_a;
            end
            if (!done_b && ((id == 0) ? ack0_b : ack1_b)) begin
                done_b = 1'b1; lat_b = c; rd_b = rdata_b;
            end
            @(posedge clock);
            #1;
            if (done_a) begin
                if (id == 0) req0_a = 1'b0; else req1_a = 1'b0;
            end
            if (done_b) begin
                if (id == 0) req0_b = 1'b0; else req1_b = 1'b0;
            end
        end
        drop_all();
        check({tag, "_lat_a"}, lat_a, we ? 1 : 3);
        check({tag, "_lat_b"}, lat_b, we ? 1 : 4);
        check({tag, "_wren_a"}, wren_a, we ? 1 : 0);
        check({tag, "_wren_b"}, wren_b, we ? 1 : 0);
        check({tag, "_wrong_ack"}, wrong, 0);
        if (!we) begin
            check({tag, "_rdata_a"}, rd_a, exp_rd);
            check({tag, "_rdata_b"}, rd_b, exp_rd);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n_a, n_b, clash, stray;
        logic ord_a [4];
        logic ord_b [4];
        logic exp_g;

        resetn = 1'b0;
        drop_all();
        we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ack0", ack0_a, 1'b0);
        check("rst_ack1", ack1_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_wren", ram_wren_a, 1'b0);
        check("rst_addr", ram_address_a, 6'h00);
        check("rst_data", ram_data_a, 8'h00);
        check("rst_rdata", rdata_a, 8'h00);
        check("rst_state", dbg_state_a, IDLE);
        check("rst_busy_b", busy_b, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // 1: read of empty RAM
        access(0, 1'b0, 6'h01, 8'h00, 8'h00, "t1_rd");

        // 2: two writes, then read both back
        access(0, 1'b1, 6'h01, 8'd4, 8'h00, "t2_wr0");
        access(1, 1'b1, 6'h02, 8'd22, 8'h00, "t2_wr1");
        access(0, 1'b0, 6'h01, 8'h00, 8'd4, "t2_rd0");
        access(1, 1'b0, 6'h02, 8'h00, 8'd22, "t2_rd1");

        // 3: simultaneous held requests right after reset
        apply_reset();
        we0 = 1'b1; addr0 = 6'h10; wdata0 = 8'hA0;
        we1 = 1'b1; addr1 = 6'h11; wdata1 = 8'hB1;
        req0_a = 1'b1; req1_a = 1'b1; req0_b = 1'b1; req1_b = 1'b1;
        n_a = 0; n_b = 0; clash = 0;
        for (int c = 0; c < 40 && (n_a < 4 || n_b < 4); c++) begin
            @(negedge clock);
            if (ack0_a && ack1_a) clash++;
            if (ack0_b && ack1_b) clash++;
            if ((ack0_a || ack1_a) && n_a < 4) begin ord_a[n_a] = ack1_a; n_a++; end
            if ((ack0_b || ack1_b) && n_b < 4) begin ord_b[n_b] = ack1_b; n_b++; end
            @(posedge clock);
            #1;
            if (n_a == 4) begin req0_a = 1'b0; req1_a = 1'b0; end
            if (n_b == 4) begin req0_b = 1'b0; req1_b = 1'b0; end
        end
        drop_all();
        check("t3_count_a", n_a, 4);
        check("t3_count_b", n_b, 4);
        check("t3_clash", clash, 0);
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = (i % 2 == 1);
`endif
            check($sformatf("t3_grant_a%0d", i), ord_a[i], exp_g);
            check($sformatf("t3_grant_b%0d", i), ord_b[i], exp_g);
        end
        repeat (2) @(posedge clock);
        #1;

        // 4: reset during ISSUE of a write
        access(0, 1'b1, 6'h3F, 8'h11, 8'h00, "t4_pre");
        we0 = 1'b1; addr0 = 6'h3F; wdata0 = 8'hAA; req0_a = 1'b1; req0_b = 1'b1;
        @(posedge clock);
        #1;
        check("t4_issue_wren", ram_wren_a, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        check("t4_wren_a", ram_wren_a, 1'b0);
        check("t4_wren_b", ram_wren_b, 1'b0);
        check("t4_ack", ack0_a, 1'b0);
        check("t4_busy", busy_a, 1'b0);
        drop_all();
        stray = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if (ack0_a || ack1_a || ack0_b || ack1_b) stray++;
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (ack0_a || ack1_a || ack0_b || ack1_b) stray++;
        end
        check("t4_no_ack", stray, 0);
        @(posedge clock);
        #1;
        access(0, 1'b0, 6'h3F, 8'h00, 8'h11, "t4_rd");

        // 5: reset during WAIT of a read
        we0 = 1'b0; addr0 = 6'h01; req0_a = 1'b1; req0_b = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("t5_in_wait", dbg_state_a, WAIT);
        check("t5_busy_pre", busy_a, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        check("t5_state_a", dbg_state_a, IDLE);
        check("t5_state_b", dbg_state_b, IDLE);
        check("t5_busy", busy_a, 1'b0);
        drop_all();
        stray = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if (ack0_a || ack1_a || ack0_b || ack1_b) stray++;
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (ack0_a || ack1_a || ack0_b || ack1_b) stray++;
        end
        check("t5_no_ack", stray, 0);
        check("t5_rdata_a", rdata_a, 8'h00);
        check("t5_rdata_b", rdata_b, 8'h00);
        @(posedge clock);
        #1;

        // 6: latency per RD_LAT and back-to-back write/read
        access(1, 1'b0, 6'h02, 8'h00, 8'd22, "t6_rd02");
        access(0, 1'b1, 6'h00, 8'h5C, 8'h00, "t6_wr00");
        access(0, 1'b0, 6'h00, 8'h00, 8'h5C, "t6_rd00");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
